// File: rtl/move_sequencer.sv
// move_sequencer
// Sequences one move on the 11x11 Hnefatafl board (GameBoard). It checks a
// requested rook-style move, executes it with two writes (destination, then
// source), then checks for and removes custodial captures around the
// destination. This block drives all of the board's read and write ports.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    move request handshake (ready only in IDLE)
//   src_x/y, dst_x/y, side   move coordinates and mover (0 attacker, 1 defender)
//   done, legal, captures    one-cycle result pulse; captures bits N,E,S,W
//   read_x/y, readData       board read port 1
//   read_x2/y2, readData2    board read port 2
//   write_x/y, writeData, write   board write port
//
// Cell encoding: 00 empty, 01 attacker, 10 defender, 11 king.
// Each board read takes two cycles: the address is held for both cycles and
// the data is sampled at the end of the second cycle (phase == 1).
module move_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] src_x,
  input  logic [3:0] src_y,
  input  logic [3:0] dst_x,
  input  logic [3:0] dst_y,
  input  logic       side,
  output logic       done,
  output logic       legal,
  output logic [3:0] captures,
  output logic [3:0] read_x,
  output logic [3:0] read_y,
  output logic [3:0] read_x2,
  output logic [3:0] read_y2,
  input  logic [1:0] readData,
  input  logic [1:0] readData2,
  output logic [1:0] writeData,
  output logic [3:0] write_x,
  output logic [3:0] write_y,
  output logic       write
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PATH, S_MOVE_DST, S_MOVE_SRC, S_CAPT_RD, S_CAPT_WR, S_DONE
  } state_t;

  state_t     state, state_n;
  logic [3:0] sx, sy, dx, dy, sx_n, sy_n, dx_n, dy_n;
  logic [3:0] cx, cy, cx_n, cy_n;     // path cursor
  logic       side_r, side_n;
  logic [1:0] piece, piece_n;         // piece being moved, read in CHECK
  logic [1:0] dir, dir_n;             // capture direction 0 N, 1 E, 2 S, 3 W
  logic       phase, phase_n;         // second cycle of a read slot
  logic [3:0] capt, capt_n;
  logic       legal_r, legal_n;

  function automatic logic is_corner(input logic [3:0] x, input logic [3:0] y);
    return (x == 4'd0 || x == 4'd10) && (y == 4'd0 || y == 4'd10);
  endfunction

  function automatic logic is_throne(input logic [3:0] x, input logic [3:0] y);
    return x == 4'd5 && y == 4'd5;
  endfunction

  // Unit step from source toward destination; 4'hF acts as -1 in 4-bit wrap.
  logic [3:0] step_x, step_y;
  assign step_x = (dx > sx) ? 4'd1 : (dx < sx) ? 4'hF : 4'd0;
  assign step_y = (dy > sy) ? 4'd1 : (dy < sy) ? 4'hF : 4'd0;

  // Neighbour n and far cell f for the current capture direction. Stepping
  // below 0 wraps to 14/15, so a single "> 10" test catches both board edges.
  logic [3:0] nx, ny, fx, fy;
  logic       off_board;
  always_comb begin
    nx = dx; ny = dy; fx = dx; fy = dy;
    case (dir)
      2'd0:    begin ny = dy - 4'd1; fy = dy - 4'd2; end
      2'd1:    begin nx = dx + 4'd1; fx = dx + 4'd2; end
      2'd2:    begin ny = dy + 4'd1; fy = dy + 4'd2; end
      default: begin nx = dx - 4'd1; fx = dx - 4'd2; end
    endcase
    off_board = (nx > 4'd10) || (ny > 4'd10) || (fx > 4'd10) || (fy > 4'd10);
  end

  logic static_ok;
  assign static_ok = (src_x <= 4'd10) && (src_y <= 4'd10) &&
                     (dst_x <= 4'd10) && (dst_y <= 4'd10) &&
                     !(src_x == dst_x && src_y == dst_y) &&
                     (src_x == dst_x || src_y == dst_y);

  logic own_ok, enemy_n, friend_f, hostile_f, capture_hit;
  assign own_ok      = side_r ? readData[1] : (readData == 2'b01);
  assign enemy_n     = side_r ? (readData == 2'b01) : (readData == 2'b10);
  assign friend_f    = side_r ? readData2[1] : (readData2 == 2'b01);
  assign hostile_f   = is_corner(fx, fy) || (is_throne(fx, fy) && readData2 == 2'b00);
  assign capture_hit = enemy_n && (friend_f || hostile_f);

  logic [3:0] first_x, first_y, next_x, next_y;
  assign first_x = sx + step_x;
  assign first_y = sy + step_y;
  assign next_x  = cx + step_x;
  assign next_y  = cy + step_y;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_n = state;
    sx_n = sx; sy_n = sy; dx_n = dx; dy_n = dy;
    cx_n = cx; cy_n = cy; side_n = side_r; piece_n = piece;
    dir_n = dir; phase_n = phase; capt_n = capt; legal_n = legal_r;
    req_ready = 1'b0; done = 1'b0; legal = 1'b0; captures = 4'd0;
    read_x = 4'd0; read_y = 4'd0; read_x2 = 4'd0; read_y2 = 4'd0;
    writeData = 2'b00; write_x = 4'd0; write_y = 4'd0; write = 1'b0;

    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          sx_n = src_x; sy_n = src_y; dx_n = dst_x; dy_n = dst_y;
          side_n = side; capt_n = 4'd0; legal_n = 1'b0; phase_n = 1'b0;
          state_n = static_ok ? S_CHECK : S_DONE;
        end
      end
      S_CHECK: begin
        read_x = sx; read_y = sy; read_x2 = dx; read_y2 = dy;
        phase_n = ~phase;
        if (phase) begin
          piece_n = readData;
          if (!own_ok || readData2 != 2'b00 ||
              ((is_corner(dx, dy) || is_throne(dx, dy)) && readData != 2'b11)) begin
            state_n = S_DONE;
          end else begin
            cx_n = first_x; cy_n = first_y;
            state_n = (first_x == dx && first_y == dy) ? S_MOVE_DST : S_PATH;
          end
        end
      end
      S_PATH: begin
        read_x = cx; read_y = cy;
        phase_n = ~phase;
        if (phase) begin
          if (readData != 2'b00) begin
            state_n = S_DONE;
          end else begin
            cx_n = next_x; cy_n = next_y;
            if (next_x == dx && next_y == dy) state_n = S_MOVE_DST;
          end
        end
      end
      S_MOVE_DST: begin
        write = 1'b1; write_x = dx; write_y = dy; writeData = piece;
        legal_n = 1'b1;
        state_n = S_MOVE_SRC;
      end
      S_MOVE_SRC: begin
        write = 1'b1; write_x = sx; write_y = sy; writeData = 2'b00;
        dir_n = 2'd0; phase_n = 1'b0;
        state_n = S_CAPT_RD;
      end
      S_CAPT_RD: begin
        if (off_board) begin
          // Direction with no room for a sandwich costs a single cycle.
          if (dir == 2'd3) state_n = S_DONE;
          else dir_n = dir + 2'd1;
        end else begin
          read_x = nx; read_y = ny; read_x2 = fx; read_y2 = fy;
          phase_n = ~phase;
          if (phase) begin
            if (capture_hit) begin
              capt_n[dir] = 1'b1;
              state_n = S_CAPT_WR;
            end else if (dir == 2'd3) begin
              state_n = S_DONE;
            end else begin
              dir_n = dir + 2'd1;
            end
          end
        end
      end
      S_CAPT_WR: begin
        write = 1'b1; write_x = nx; write_y = ny; writeData = 2'b00;
        if (dir == 2'd3) begin
          state_n = S_DONE;
        end else begin
          dir_n = dir + 2'd1;
          state_n = S_CAPT_RD;
        end
      end
      S_DONE: begin
        done = 1'b1; legal = legal_r; captures = capt;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are held quiet during reset so an abort never issues a write.
    if (rst) begin
      req_ready = 1'b0; done = 1'b0; legal = 1'b0; captures = 4'd0;
      read_x = 4'd0; read_y = 4'd0; read_x2 = 4'd0; read_y2 = 4'd0;
      writeData = 2'b00; write_x = 4'd0; write_y = 4'd0; write = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sx <= 4'd0; sy <= 4'd0; dx <= 4'd0; dy <= 4'd0;
      cx <= 4'd0; cy <= 4'd0; side_r <= 1'b0; piece <= 2'b00;
      dir <= 2'd0; phase <= 1'b0; capt <= 4'd0; legal_r <= 1'b0;
    end else begin
      state <= state_n;
      sx <= sx_n; sy <= sy_n; dx <= dx_n; dy <= dy_n;
      cx <= cx_n; cy <= cy_n; side_r <= side_n; piece <= piece_n;
      dir <= dir_n; phase <= phase_n; capt <= capt_n; legal_r <= legal_n;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a behavioural 11x11 board that has
// registered reads and writes visible on the following cycle.
module tb_move_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] src_x, src_y, dst_x, dst_y;
  logic       side;
  logic       done, legal;
  logic [3:0] captures;
  logic [3:0] read_x, read_y, read_x2, read_y2;
  logic [1:0] readData, readData2;
  logic [1:0] writeData;
  logic [3:0] write_x, write_y;
  logic       write;

  move_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y), .side(side),
    .done(done), .legal(legal), .captures(captures),
    .read_x(read_x), .read_y(read_y), .read_x2(read_x2), .read_y2(read_y2),
    .readData(readData), .readData2(readData2),
    .writeData(writeData), .write_x(write_x), .write_y(write_y), .write(write)
  );

  always #5 clk = ~clk;

  // Board model
  logic [1:0] mem [0:120];
  logic       board_clr, tb_put;
  logic [3:0] tb_x, tb_y;
  logic [1:0] tb_v;

  function automatic int idx(input logic [3:0] x, input logic [3:0] y);
    return int'(y) * 11 + int'(x);
  endfunction

  always @(posedge clk) begin
    readData  <= (read_x  <= 4'd10 && read_y  <= 4'd10) ? mem[idx(read_x, read_y)]   : 2'b00;
    readData2 <= (read_x2 <= 4'd10 && read_y2 <= 4'd10) ? mem[idx(read_x2, read_y2)] : 2'b00;
    if (board_clr) begin
      for (int i = 0; i < 121; i++) mem[i] <= 2'b00;
    end else if (write) begin
      mem[idx(write_x, write_y)] <= writeData;
    end else if (tb_put) begin
      mem[idx(tb_x, tb_y)] <= tb_v;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [3:0] x, input logic [3:0] y, input logic [1:0] v);
    @(negedge clk);
    tb_put = 1'b1; tb_x = x; tb_y = y; tb_v = v;
    @(negedge clk);
    tb_put = 1'b0;
  endtask

  // Results of the last move
  int         done_cyc;
  logic       legal_seen;
  logic [3:0] capt_seen;
  int         nwr;
  int         wr_cyc [8];
  logic [3:0] wr_x [8];
  logic [3:0] wr_y [8];
  logic [1:0] wr_d [8];

  task automatic run_move(input logic [3:0] sx, input logic [3:0] sy,
                          input logic [3:0] tx, input logic [3:0] ty,
                          input logic sd, input int budget);
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; src_x = sx; src_y = sy; dst_x = tx; dst_y = ty; side = sd;
    done_cyc = -1; legal_seen = 1'b0; capt_seen = 4'd0; nwr = 0;
    for (int i = 0; i < 8; i++) begin
      wr_cyc[i] = -1; wr_x[i] = 4'd0; wr_y[i] = 4'd0; wr_d[i] = 2'b00;
    end
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      // Scramble inputs after accept: the request must already be latched.
      req_valid = 1'b0; src_x = 4'd9; src_y = 4'd9; dst_x = 4'd8; dst_y = 4'd8; side = ~sd;
      if (write) begin
        if (nwr < 8) begin
          wr_cyc[nwr] = c; wr_x[nwr] = write_x; wr_y[nwr] = write_y; wr_d[nwr] = writeData;
        end
        nwr++;
      end
      if (done) begin
        done_cyc = c; legal_seen = legal; capt_seen = captures;
        break;
      end
    end
    if (done_cyc < 0) check("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic check_wr(input string tag, input int i, input int cyc,
                          input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
    check({tag, "_cyc"}, wr_cyc[i], cyc);
    check({tag, "_xy"}, {24'd0, wr_x[i], wr_y[i]}, {24'd0, x, y});
    check({tag, "_data"}, {30'd0, wr_d[i]}, {30'd0, d});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; side = 1'b0;
    src_x = 4'd0; src_y = 4'd0; dst_x = 4'd0; dst_y = 4'd0;
    board_clr = 1'b1; tb_put = 1'b0; tb_x = 4'd0; tb_y = 4'd0; tb_v = 2'b00;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_addr", {16'd0, read_x, read_y, read_x2, read_y2}, 32'd0);
    check("rst_wport", {22'd0, write_x, write_y, writeData}, 32'd0);
    rst = 1'b0; board_clr = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Legal plain move, one intermediate
    put(4'd3, 4'd0, 2'b01);
    run_move(4'd3, 4'd0, 4'd3, 4'd2, 1'b0, 40);
    check("plain_done_cyc", done_cyc, 15);
    check("plain_legal", {31'd0, legal_seen}, 32'd1);
    check("plain_capt", {28'd0, capt_seen}, 32'd0);
    check("plain_nwr", nwr, 2);
    check_wr("plain_w0", 0, 5, 4'd3, 4'd2, 2'b01);
    check_wr("plain_w1", 1, 6, 4'd3, 4'd0, 2'b00);

    // Blocked path: fails at second intermediate
    put(4'd0, 4'd3, 2'b01);
    put(4'd2, 4'd3, 2'b10);
    run_move(4'd0, 4'd3, 4'd4, 4'd3, 1'b0, 40);
    check("block_done_cyc", done_cyc, 7);
    check("block_legal", {31'd0, legal_seen}, 32'd0);
    check("block_nwr", nwr, 0);

    // Capture to the south
    put(4'd7, 4'd7, 2'b10);
    put(4'd7, 4'd8, 2'b01);
    put(4'd4, 4'd6, 2'b01);
    run_move(4'd4, 4'd6, 4'd7, 4'd6, 1'b0, 40);
    check("capt_done_cyc", done_cyc, 18);
    check("capt_legal", {31'd0, legal_seen}, 32'd1);
    check("capt_bits", {28'd0, capt_seen}, 32'b0100);
    check("capt_nwr", nwr, 3);
    check_wr("capt_w0", 0, 7, 4'd7, 4'd6, 2'b01);
    check_wr("capt_w1", 1, 8, 4'd4, 4'd6, 2'b00);
    check_wr("capt_w2", 2, 15, 4'd7, 4'd7, 2'b00);
    check("capt_board", {30'd0, mem[idx(4'd7, 4'd7)]}, 32'd0);

    // Defender onto empty throne, then attacker moving a defender
    put(4'd5, 4'd3, 2'b10);
    run_move(4'd5, 4'd3, 4'd5, 4'd5, 1'b1, 40);
    check("throne_done_cyc", done_cyc, 3);
    check("throne_legal", {31'd0, legal_seen}, 32'd0);
    check("throne_nwr", nwr, 0);
    run_move(4'd5, 4'd3, 4'd5, 4'd4, 1'b0, 40);
    check("owner_done_cyc", done_cyc, 3);
    check("owner_legal", {31'd0, legal_seen}, 32'd0);
    check("owner_capt", {28'd0, capt_seen}, 32'd0);

    // Static failures
    run_move(4'd1, 4'd1, 4'd2, 4'd2, 1'b0, 40);
    check("diag_done_cyc", done_cyc, 1);
    check("diag_legal", {31'd0, legal_seen}, 32'd0);
    run_move(4'd0, 4'd11, 4'd0, 4'd4, 1'b0, 40);
    check("range_done_cyc", done_cyc, 1);
    check("range_legal", {31'd0, legal_seen}, 32'd0);

    // Edge destination: N and W off board, capture to the east
    put(4'd1, 4'd1, 2'b10);
    put(4'd2, 4'd1, 2'b01);
    run_move(4'd0, 4'd3, 4'd0, 4'd1, 1'b0, 40);
    check("edge_done_cyc", done_cyc, 14);
    check("edge_legal", {31'd0, legal_seen}, 32'd1);
    check("edge_capt", {28'd0, capt_seen}, 32'b0010);
    check("edge_nwr", nwr, 3);
    check_wr("edge_w2", 2, 10, 4'd1, 4'd1, 2'b00);

    // Reset during PATH of a long move
    put(4'd10, 4'd0, 2'b01);
    @(negedge clk);
    req_valid = 1'b1; src_x = 4'd10; src_y = 4'd0; dst_x = 4'd10; dst_y = 4'd9; side = 1'b0;
    nwr = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (write) nwr++;
    end
    rst = 1'b1;
    #1;
    check("abort_rst_write", {31'd0, write}, 32'd0);
    check("abort_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (write || done) nwr++;
    end
    check("abort_quiet", nwr, 0);
    check("abort_board_src", {30'd0, mem[idx(4'd10, 4'd0)]}, 32'd1);
    check("abort_board_dst", {30'd0, mem[idx(4'd10, 4'd9)]}, 32'd0);

    run_move(4'd10, 4'd0, 4'd10, 4'd9, 1'b0, 60);
    check("long_done_cyc", done_cyc, 27);
    check("long_legal", {31'd0, legal_seen}, 32'd1);
    check("long_capt", {28'd0, capt_seen}, 32'd0);
    check_wr("long_w0", 0, 19, 4'd10, 4'd9, 2'b01);
    check_wr("long_w1", 1, 20, 4'd10, 4'd0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
